fpa_operand_stage: RTL

Registered input stage that sits directly upstream of the combinational single-precision adder (fpa). It accepts an operand pair over a valid/ready handshake and unpacks both operands. It classifies special values and swaps the pair so the larger magnitude is first. It then computes the alignment shift and presents the result to the adder datapath through a 2-entry skid buffer, giving full throughput with a registered in_ready.

---
 rtl/fpa_pkg.sv | 37 +++
 rtl/fpa_operand_stage_if.sv | 38 +++
 rtl/fpa_unpack.sv | 31 +++
 rtl/fpa_operand_stage.sv | 138 +++++++++++++
 4 files changed

// File: rtl/fpa_pkg.sv
// Shared widths, constants, operand classes and the registered output bundle
// for the adder operand stage.
package fpa_pkg;

    localparam int EXP_W     = 8;
    localparam int MANT_W    = 23;
    localparam int SHIFT_SAT = MANT_W + 3;
    localparam int SHIFT_W   = 5;
    localparam int WORD_W    = 1 + EXP_W + MANT_W;

    localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;

    // Five classes need three bits of encoding.
    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NORMAL = 3'd2,
        CLS_INF    = 3'd3,
        CLS_NAN    = 3'd4
    } op_class_t;

    typedef struct packed {
        logic               big_sign;
        logic [EXP_W-1:0]   big_exp;
        logic [MANT_W:0]    big_mant;
        logic               small_sign;
        logic [EXP_W-1:0]   small_exp;
        logic [MANT_W:0]    small_mant;
        logic [EXP_W-1:0]   exp_diff;
        logic [SHIFT_W-1:0] shift_amt;
        logic               eff_sub;
        logic               special;
        logic [WORD_W-1:0]  special_result;
    } bundle_t;

endpackage

// File: rtl/fpa_operand_stage_if.sv
// Operand-pair input handshake and unpacked-bundle output handshake between
// the producer, the operand stage and the adder datapath.
interface fpa_operand_stage_if;
    import fpa_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [WORD_W-1:0]   number_A;
    logic [WORD_W-1:0]   number_B;
    logic                out_valid;
    logic                out_ready;
    logic                big_sign;
    logic [EXP_W-1:0]    big_exp;
    logic [MANT_W:0]     big_mant;
    logic                small_sign;
    logic [EXP_W-1:0]    small_exp;
    logic [MANT_W:0]     small_mant;
    logic [EXP_W-1:0]    exp_diff;
    logic [SHIFT_W-1:0]  shift_amt;
    logic                eff_sub;
    logic                special;
    logic [WORD_W-1:0]   special_result;

    modport master (
        output in_valid, number_A, number_B, out_ready,
        input  in_ready, out_valid, big_sign, big_exp, big_mant,
               small_sign, small_exp, small_mant, exp_diff, shift_amt,
               eff_sub, special, special_result
    );

    modport slave (
        input  in_valid, number_A, number_B, out_ready,
        output in_ready, out_valid, big_sign, big_exp, big_mant,
               small_sign, small_exp, small_mant, exp_diff, shift_amt,
               eff_sub, special, special_result
    );

endinterface

// File: rtl/fpa_unpack.sv
// Classifies one single-precision operand and derives its hidden bit and
// effective exponent (zero and denormals use exponent 1).
module fpa_unpack
    import fpa_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    output op_class_t         o_class,
    output logic              o_hidden,
    output logic [EXP_W-1:0]  o_eff_exp
);

    logic [EXP_W-1:0]  w_exp;
    logic [MANT_W-1:0] w_frac;

    assign w_exp  = i_word[WORD_W-2 -: EXP_W];
    assign w_frac = i_word[MANT_W-1:0];

    always_comb begin
        o_class   = CLS_NORMAL;
        o_hidden  = 1'b1;
        o_eff_exp = w_exp;
        if (w_exp == EXP_MAX) begin
            o_class = (w_frac != '0) ? CLS_NAN : CLS_INF;
        end else if (w_exp == '0) begin
            o_class   = (w_frac != '0) ? CLS_DENORM : CLS_ZERO;
            o_hidden  = 1'b0;
            o_eff_exp = EXP_W'(1);
        end
    end

endmodule

// File: rtl/fpa_operand_stage.sv
// Registered operand stage ahead of the single-precision adder: unpack, swap
// by magnitude, resolve NaN/Inf, compute alignment, then a 2-entry skid buffer.
module fpa_operand_stage
    import fpa_pkg::*;
(
    input  logic clk,
    input  logic rst,
    fpa_operand_stage_if.slave bus
);

    function automatic logic [SHIFT_W-1:0] sat_shift(input logic [EXP_W-1:0] diff);
        if (diff > EXP_W'(SHIFT_SAT))
            return SHIFT_W'(SHIFT_SAT);
        return diff[SHIFT_W-1:0];
    endfunction

    // Returns {special, special_result}.
    function automatic logic [WORD_W:0] resolve_special(
        input logic [WORD_W-1:0] a,
        input logic [WORD_W-1:0] b,
        input op_class_t         cls_a,
        input op_class_t         cls_b
    );
        logic inf_clash;
        inf_clash = (cls_a == CLS_INF) && (cls_b == CLS_INF) &&
                    (a[WORD_W-1] != b[WORD_W-1]);
        if ((cls_a == CLS_NAN) || (cls_b == CLS_NAN) || inf_clash)
            return {1'b1, QNAN};
        if (cls_a == CLS_INF)
            return {1'b1, a};
        if (cls_b == CLS_INF)
            return {1'b1, b};
        return '0;
    endfunction

    op_class_t         w_cls_a, w_cls_b;
    logic              w_hid_a, w_hid_b;
    logic [EXP_W-1:0]  w_exp_a, w_exp_b;
    logic              w_b_gt;
    logic [WORD_W:0]   w_spec;
    bundle_t           w_bundle_p0;

    logic              w_accept;
    logic              w_drain;
    logic              r_in_ready;
    logic              r_or_vld_p1;
    logic              r_sk_vld_p1;
    bundle_t           r_or_p1;
    bundle_t           r_sk_p1;

    fpa_unpack u_unpack_a (
        .i_word    (bus.number_A),
        .o_class   (w_cls_a),
        .o_hidden  (w_hid_a),
        .o_eff_exp (w_exp_a)
    );

    fpa_unpack u_unpack_b (
        .i_word    (bus.number_B),
        .o_class   (w_cls_b),
        .o_hidden  (w_hid_b),
        .o_eff_exp (w_exp_b)
    );

    // Stage p0: swap so big >= small in magnitude; ties keep A as big.
    assign w_b_gt = bus.number_B[WORD_W-2:0] > bus.number_A[WORD_W-2:0];
    assign w_spec = resolve_special(bus.number_A, bus.number_B, w_cls_a, w_cls_b);

    always_comb begin
        w_bundle_p0 = '0;
        if (w_b_gt) begin
            w_bundle_p0.big_sign   = bus.number_B[WORD_W-1];
            w_bundle_p0.big_exp    = w_exp_b;
            w_bundle_p0.big_mant   = {w_hid_b, bus.number_B[MANT_W-1:0]};
            w_bundle_p0.small_sign = bus.number_A[WORD_W-1];
            w_bundle_p0.small_exp  = w_exp_a;
            w_bundle_p0.small_mant = {w_hid_a, bus.number_A[MANT_W-1:0]};
        end else begin
            w_bundle_p0.big_sign   = bus.number_A[WORD_W-1];
            w_bundle_p0.big_exp    = w_exp_a;
            w_bundle_p0.big_mant   = {w_hid_a, bus.number_A[MANT_W-1:0]};
            w_bundle_p0.small_sign = bus.number_B[WORD_W-1];
            w_bundle_p0.small_exp  = w_exp_b;
            w_bundle_p0.small_mant = {w_hid_b, bus.number_B[MANT_W-1:0]};
        end
        w_bundle_p0.exp_diff       = w_bundle_p0.big_exp - w_bundle_p0.small_exp;
        w_bundle_p0.shift_amt      = sat_shift(w_bundle_p0.exp_diff);
        w_bundle_p0.eff_sub        = w_bundle_p0.big_sign ^ w_bundle_p0.small_sign;
        w_bundle_p0.special        = w_spec[WORD_W];
        w_bundle_p0.special_result = w_spec[WORD_W-1:0];
    end

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_drain  = r_or_vld_p1 & bus.out_ready;

    // Stage p1: output register with skid; in_ready drops only while SK holds a pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_or_vld_p1 <= 1'b0;
            r_sk_vld_p1 <= 1'b0;
            r_or_p1     <= '0;
            r_sk_p1     <= '0;
        end else if (r_sk_vld_p1) begin
            if (w_drain) begin
                r_or_p1     <= r_sk_p1;
                r_sk_vld_p1 <= 1'b0;
                r_in_ready  <= 1'b1;
            end
        end else if (w_accept) begin
            if (!r_or_vld_p1 || w_drain) begin
                r_or_p1     <= w_bundle_p0;
                r_or_vld_p1 <= 1'b1;
            end else begin
                r_sk_p1     <= w_bundle_p0;
                r_sk_vld_p1 <= 1'b1;
                r_in_ready  <= 1'b0;
            end
        end else if (w_drain) begin
            r_or_vld_p1 <= 1'b0;
        end
    end

    assign bus.in_ready       = r_in_ready;
    assign bus.out_valid      = r_or_vld_p1;
    assign bus.big_sign       = r_or_p1.big_sign;
    assign bus.big_exp        = r_or_p1.big_exp;
    assign bus.big_mant       = r_or_p1.big_mant;
    assign bus.small_sign     = r_or_p1.small_sign;
    assign bus.small_exp      = r_or_p1.small_exp;
    assign bus.small_mant     = r_or_p1.small_mant;
    assign bus.exp_diff       = r_or_p1.exp_diff;
    assign bus.shift_amt      = r_or_p1.shift_amt;
    assign bus.eff_sub        = r_or_p1.eff_sub;
    assign bus.special        = r_or_p1.special;
    assign bus.special_result = r_or_p1.special_result;

endmodule
